// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_pkg : shared constants, types and preload helper for regfile     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;
  localparam int NUM_PHYS = ZERO_REG;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [NUM_PHYS-1:0][DATA_W-1:0] reg_array_t;

  localparam reg_addr_t XZR_ADDR = reg_addr_t'(ZERO_REG);

  // Xi = i for every physical register.
  function automatic reg_array_t preload();
    reg_array_t r;
    for (int i = 0; i < NUM_PHYS; i++) begin
      r[i] = reg_data_t'(i);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_rd_port : combinational read mux, XZR reads as zero              |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module regfile_rd_port
  import regfile_pkg::*;
(
  input  reg_array_t mem_i,
  input  reg_addr_t  ra_i,
  output reg_data_t  rd_o
);

  assign rd_o = (ra_i == XZR_ADDR) ? '0 : mem_i[ra_i];

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile : 32 x 64-bit register file, 2 async read ports, 1 sync write    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module regfile
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  // Power-up contents match the reset contents.
  reg_array_t mem_q = preload();
  reg_array_t mem_d;

  // Reset wins over a same-edge write; XZR has no storage so its writes drop.
  always_comb begin
    mem_d = mem_q;
    if (reset) begin
      mem_d = preload();
    end else if (we3 && (wa3 != XZR_ADDR)) begin
      mem_d[wa3] = wd3;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  regfile_rd_port u_rd_port1 (
    .mem_i (mem_q),
    .ra_i  (ra1),
    .rd_o  (rd1)
  );

  regfile_rd_port u_rd_port2 (
    .mem_i (mem_q),
    .ra_i  (ra2),
    .rd_o  (rd2)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile : directed self-checking bench for regfile                    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        we3;
  logic [4:0]  ra1, ra2, wa3;
  logic [63:0] wd3;
  logic [63:0] rd1, rd2;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_mem [0:30];

  regfile dut (
    .clk   (clk),
    .reset (reset),
    .we3   (we3),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance past the next rising edge so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; we3 = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0;
    tick();
    reset = 1'b0;

    // Preload sweep, including XZR.
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i);
      #1;
      check($sformatf("preload_rd1[%0d]", i), rd1, (i == 31) ? 64'd0 : 64'(i));
      check($sformatf("preload_rd2[%0d]", i), rd2, (i == 31) ? 64'd0 : 64'(i));
    end
    for (int i = 0; i < 31; i++) exp_mem[i] = 64'(i);

    // Write X5; no bypass before the edge.
    we3 = 1'b1; wa3 = 5'd5; wd3 = 64'hDEADBEEF_DEADBEEF; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    check("no_bypass_x5", rd1, 64'd5);
    tick();
    check("wr_x5_rd1", rd1, 64'hDEADBEEF_DEADBEEF);
    check("wr_x5_rd2", rd2, 64'hDEADBEEF_DEADBEEF);

    // Random data into every physical register, then read all back.
    for (int i = 0; i < 31; i++) begin
      wa3 = 5'(i);
      wd3 = {$urandom, $urandom};
      exp_mem[i] = wd3;
      tick();
    end
    we3 = 1'b0;
    for (int i = 0; i < 31; i++) begin
      ra1 = 5'(i); ra2 = 5'(30 - i);
      #1;
      check($sformatf("rand_rd1[%0d]", i), rd1, exp_mem[i]);
      check($sformatf("rand_rd2[%0d]", 30 - i), rd2, exp_mem[30 - i]);
    end

    // XZR write protection.
    we3 = 1'b1; wa3 = 5'd31; wd3 = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    we3 = 1'b0; ra1 = 5'd31; ra2 = 5'd30;
    #1;
    check("xzr_rd1", rd1, 64'd0);
    check("x30_kept", rd2, exp_mem[30]);

    // Write disable leaves contents alone.
    we3 = 1'b0; wa3 = 5'd3; wd3 = 64'h1234;
    tick();
    ra1 = 5'd3;
    #1;
    check("we_off_x3", rd1, exp_mem[3]);

    // Back to preload, then dual-port independence.
    reset = 1'b1;
    tick();
    reset = 1'b0; ra1 = 5'd2; ra2 = 5'd30;
    #1;
    check("dual_rd1_x2", rd1, 64'd2);
    check("dual_rd2_x30", rd2, 64'd30);
    we3 = 1'b1; wa3 = 5'd2; wd3 = 64'hA5;
    tick();
    we3 = 1'b0;
    #1;
    check("dual_rd1_x2_wr", rd1, 64'hA5);
    check("dual_rd2_x30_kept", rd2, 64'd30);

    // Synchronous reset beats a same-edge write and waits for the edge.
    we3 = 1'b1; wa3 = 5'd10; wd3 = 64'h55;
    tick();
    ra1 = 5'd10; ra2 = 5'd2;
    #1;
    check("x10_wr55", rd1, 64'h55);
    reset = 1'b1; we3 = 1'b1; wa3 = 5'd10; wd3 = 64'h99;
    #1;
    check("rst_pending_x10", rd1, 64'h55);
    check("rst_pending_x2", rd2, 64'hA5);
    tick();
    reset = 1'b0; we3 = 1'b0;
    #1;
    check("rst_x10", rd1, 64'd10);
    check("rst_x2", rd2, 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile.md
Name: regfile

Overview:
- LEGv8-style integer register file for the single-cycle processor datapath: 32 registers × 64 bits, two combinational read ports, one synchronous write port.
- Register X31 is the hard-wired zero register (XZR).
- Contents come up preloaded so that Xi = i. This gives the datapath a deterministic state without a software init sequence.

Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, register address width (2^ADDR_W = 32 registers).
- ZERO_REG, 31, index of the hard-wired zero register (XZR).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high; restores preload contents.
- we3, input, 1, write enable for write port 3.
- ra1, input, 5, read address, port 1.
- ra2, input, 5, read address, port 2.
- wa3, input, 5, write address, port 3.
- wd3, input, 64, write data, port 3.
- rd1, output, 64, read data, port 1.
- rd2, output, 64, read data, port 2.

Behaviour:
- Storage: 31 physical registers X0..X30, 64 bits each. X31 has no storage; reads of it always return 64'd0.
- Preload/reset value: Xi = i (zero-extended to 64 bits) for i = 0..30. Thus X0=0, X1=1, …, X30=30.
  - Applied as the initial (power-up) value of the array.
  - Also applied on any rising clk edge with reset=1.
- Reset priority: reset overrides we3 on the same edge; the write is discarded.
- Write path:
  - On a rising clk edge with reset=0 and we3=1, mem[wa3] <= wd3.
  - If wa3 = 31, the write is silently ignored and X31 still reads 0.
  - we3=0 leaves all contents unchanged.
- Read path: purely combinational, zero latency.
  - rd1 = (ra1==31) ? 0 : mem[ra1]; same form for rd2 with ra2.
  - Outputs settle within the same cycle the address changes. No clock or enable gates the reads.
- Write-then-read timing: a value written at rising edge N appears on rdX (when raX==wa3) immediately after edge N. It is stable well before the following falling edge.
- Read/write of the same address in the same cycle: before the edge, rdX shows the old value. There is no write-to-read bypass of wd3.
- Both ports may read the same address simultaneously; both return identical data.
- Out-of-range behaviour: none possible, since all 5-bit addresses are valid.
- Outputs during reset: combinational. They show preload values once the reset edge has occurred.

Decomposition:
- Shared package (regfile_pkg or the existing datapath package) holds:
  - DATA_W, ADDR_W, ZERO_REG constants.
  - A reg_addr_t typedef (logic [4:0]).
  - A reg_data_t typedef (logic [63:0]).
- Sub-module: none required; a single module with the array, the write always_ff, and two read assigns.
- Optional: factor the zero-masking read mux into regfile_rd_port, instantiated twice, if it is reused elsewhere.

Test Plan:
- Preload check: no writes, we3=0; sweep ra1=ra2=i for i=0..31 → rd1=rd2=i for i≤30, and 0 for i=31 (e.g. ra1=7 → 64'd7).
- Write/readback: we3=1, wa3=ra1=ra2=5, wd3=64'hDEADBEEF_DEADBEEF; after the rising edge → rd1=rd2=64'hDEADBEEF_DEADBEEF. Repeat with random data for all i=0..30.
- XZR protection: we3=1, wa3=31, wd3=64'hFFFF_FFFF_FFFF_FFFF; after the edge, ra1=31 → rd1=0, and X30 still reads its previous value.
- Write-disable: we3=0, wa3=3, wd3=64'h1234; after the edge → ra1=3 still returns 3.
- Dual-port independence: ra1=2, ra2=30 with no writes → rd1=2, rd2=30 in the same cycle. Write X2=64'hA5 → rd1=64'hA5 while rd2 remains 30.
- Synchronous reset: write X10=64'h55, then hold reset=1 for one edge with we3=1, wa3=10, wd3=64'h99 → ra1=10 reads 10. Asserting reset between edges has no effect until the next rising edge.
